// File: rtl/ray_pkg.sv
// Shared fixed-point types and helpers for the ray marcher and menger_sdf.
// All values are signed Q(BITS-FIXED).FIXED.
package ray_pkg;

    localparam int BITS  = 32;
    localparam int FIXED = 16;

    typedef logic signed [BITS-1:0] fx_t;

    typedef struct packed {
        fx_t x;
        fx_t y;
        fx_t z;
    } vec3_t;

    function automatic fx_t to_fixed(input int i);
        return fx_t'(i) <<< FIXED;
    endfunction

    // Full-width product, rescaled and truncated back to the word width.
    function automatic fx_t mult(input fx_t a, input fx_t b);
        logic signed [2*BITS-1:0] prod;
        prod = a * b;
        return prod[FIXED +: BITS];
    endfunction

    function automatic fx_t abs(input fx_t a);
        return (a < fx_t'(0)) ? -a : a;
    endfunction

endpackage

// File: rtl/ray_march_stepper_vec3_mac.sv
// Combinational per-axis multiply-accumulate: p_out = p + mult(d, s), wrapping.
module vec3_mac
    import ray_pkg::*;
(
    input  vec3_t p_in,
    input  vec3_t d_in,
    input  fx_t   s_in,
    output vec3_t p_out
);

    assign p_out.x = p_in.x + mult(d_in.x, s_in);
    assign p_out.y = p_in.y + mult(d_in.y, s_in);
    assign p_out.z = p_in.z + mult(d_in.z, s_in);

endmodule

// File: rtl/ray_march_stepper.sv
// Sphere-tracing controller: walks one ray through menger_sdf until hit, clip or step limit.
// Optional macro STEP_SHADE_EN darkens hit colour by step count.
module ray_march_stepper
    import ray_pkg::*;
#(
    parameter int  MAX_STEPS = 64,
    parameter fx_t HIT_EPS   = 32'sh0000_0400,
    parameter fx_t MAX_DIST  = 32'sh00C8_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        ray_valid_in,
    output logic        ray_ready_out,
    input  vec3_t       ray_origin_in,
    input  vec3_t       ray_dir_in,
    input  logic [19:0] pixel_id_in,
    output logic        sdf_start_out,
    output fx_t         sdf_x_out,
    output fx_t         sdf_y_out,
    output fx_t         sdf_z_out,
    input  logic        sdf_done_in,
    input  fx_t         sdf_dist_in,
    input  logic [23:0] sdf_rgb_in,
    output logic        result_valid_out,
    input  logic        result_ready_in,
    output logic        hit_out,
    output logic [7:0]  steps_out,
    output logic [19:0] pixel_id_out,
    output logic [23:0] rgb_out
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_EVAL   = 3'd3;
    localparam logic [2:0] S_STEP   = 3'd4;
    localparam logic [2:0] S_RESULT = 3'd5;

    localparam logic [7:0] MAX_STEPS_C = 8'(MAX_STEPS);

    logic [2:0]  state_q, state_d;
    vec3_t       p_q, p_d, d_q, d_d, pt_q, pt_d, mac_p_s;
    fx_t         t_q, t_d, dist_q, dist_d;
    logic [7:0]  steps_q, steps_d, steps_out_q, steps_out_d;
    logic [23:0] rgb_q, rgb_d, rgb_out_q, rgb_out_d, shaded_rgb_s;
    logic [19:0] tag_q, tag_d, pix_out_q, pix_out_d;
    logic        hit_q, hit_d, start_q, start_d, rv_q, rv_d, rdy_q, rdy_d;
    logic signed [BITS:0] t_sum_s;
    logic        near_s, far_s;

    vec3_mac u_mac (
        .p_in  (p_q),
        .d_in  (d_q),
        .s_in  (dist_q),
        .p_out (mac_p_s)
    );

    // Accumulated distance is compared one bit wider so a wrapped sum never looks close.
    assign t_sum_s = {t_q[BITS-1], t_q} + {dist_q[BITS-1], dist_q};
    assign far_s   = (t_sum_s >= $signed({1'b0, MAX_DIST}));
    assign near_s  = (dist_q < HIT_EPS);

`ifdef STEP_SHADE_EN
    logic [4:0] shade_raw_s;
    logic [2:0] shade_amt_s;
    // Darken each channel by min(steps/8, 7) bits.
    always_comb begin
        shade_raw_s  = steps_q[7:3];
        shade_amt_s  = (shade_raw_s > 5'd7) ? 3'd7 : shade_raw_s[2:0];
        shaded_rgb_s = {rgb_q[23:16] >> shade_amt_s,
                        rgb_q[15:8]  >> shade_amt_s,
                        rgb_q[7:0]   >> shade_amt_s};
    end
`else
    assign shaded_rgb_s = rgb_q;
`endif

    // Next-state and datapath logic for the marching FSM.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        d_d         = d_q;
        t_d         = t_q;
        steps_d     = steps_q;
        dist_d      = dist_q;
        rgb_d       = rgb_q;
        tag_d       = tag_q;
        hit_d       = hit_q;
        steps_out_d = steps_out_q;
        rgb_out_d   = rgb_out_q;
        pix_out_d   = pix_out_q;
        case (state_q)
            S_IDLE: begin
                if (ray_valid_in) begin
                    state_d = S_ISSUE;
                    p_d     = ray_origin_in;
                    d_d     = ray_dir_in;
                    tag_d   = pixel_id_in;
                    t_d     = '0;
                    steps_d = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (sdf_done_in) begin
                    state_d = S_EVAL;
                    dist_d  = sdf_dist_in;
                    rgb_d   = sdf_rgb_in;
                    steps_d = steps_q + 8'd1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_EVAL: begin
                if (near_s) begin
                    state_d     = S_RESULT;
                    hit_d       = 1'b1;
                    rgb_out_d   = shaded_rgb_s;
                    steps_out_d = steps_q;
                    pix_out_d   = tag_q;
                end else if ((steps_q == MAX_STEPS_C) || far_s) begin
                    state_d     = S_RESULT;
                    hit_d       = 1'b0;
                    rgb_out_d   = 24'd0;
                    steps_out_d = steps_q;
                    pix_out_d   = tag_q;
                end else begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                p_d     = mac_p_s;
                t_d     = t_q + dist_q;
                state_d = S_ISSUE;
            end
            S_RESULT: begin
                if (result_ready_in) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESULT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        start_d = (state_d == S_ISSUE);
        pt_d    = (state_d == S_ISSUE) ? p_d : pt_q;
        rv_d    = (state_d == S_RESULT);
        rdy_d   = (state_d == S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            p_q         <= '0;
            d_q         <= '0;
            pt_q        <= '0;
            t_q         <= '0;
            dist_q      <= '0;
            steps_q     <= 8'd0;
            steps_out_q <= 8'd0;
            rgb_q       <= 24'd0;
            rgb_out_q   <= 24'd0;
            tag_q       <= 20'd0;
            pix_out_q   <= 20'd0;
            hit_q       <= 1'b0;
            start_q     <= 1'b0;
            rv_q        <= 1'b0;
            rdy_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            d_q         <= d_d;
            pt_q        <= pt_d;
            t_q         <= t_d;
            dist_q      <= dist_d;
            steps_q     <= steps_d;
            steps_out_q <= steps_out_d;
            rgb_q       <= rgb_d;
            rgb_out_q   <= rgb_out_d;
            tag_q       <= tag_d;
            pix_out_q   <= pix_out_d;
            hit_q       <= hit_d;
            start_q     <= start_d;
            rv_q        <= rv_d;
            rdy_q       <= rdy_d;
        end
    end

    assign ray_ready_out    = rdy_q;
    assign sdf_start_out    = start_q;
    assign sdf_x_out        = pt_q.x;
    assign sdf_y_out        = pt_q.y;
    assign sdf_z_out        = pt_q.z;
    assign result_valid_out = rv_q;
    assign hit_out          = hit_q;
    assign steps_out        = steps_out_q;
    assign pixel_id_out     = pix_out_q;
    assign rgb_out          = rgb_out_q;

endmodule

// File: tb/tb_ray_march_stepper.sv
// Directed bench for ray_march_stepper with a latency-5 behavioural SDF stub.
module tb_ray_march_stepper;
    import ray_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ray_valid = 1'b0;
    logic        ray_ready;
    vec3_t       origin = '0;
    vec3_t       dir = '0;
    logic [19:0] pix_in = 20'd0;
    logic        sdf_start;
    fx_t         sdf_x, sdf_y, sdf_z;
    logic        sdf_done = 1'b0;
    fx_t         sdf_dist = '0;
    logic [23:0] sdf_rgb = 24'hA1B2C3;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        hit;
    logic [7:0]  steps;
    logic [19:0] pix_out;
    logic [23:0] rgb;

    int checks = 0;
    int errors = 0;

    // Stub state
    int   mode = 0;
    int   stub_cnt = 0;
    fx_t  stub_z = '0;
    int   start_cnt = 0;
    int   done_cnt = 0;
    fx_t  z_log [0:255];

    ray_march_stepper dut (
        .clk_in(clk), .rst_in(rst),
        .ray_valid_in(ray_valid), .ray_ready_out(ray_ready),
        .ray_origin_in(origin), .ray_dir_in(dir), .pixel_id_in(pix_in),
        .sdf_start_out(sdf_start), .sdf_x_out(sdf_x), .sdf_y_out(sdf_y), .sdf_z_out(sdf_z),
        .sdf_done_in(sdf_done), .sdf_dist_in(sdf_dist), .sdf_rgb_in(sdf_rgb),
        .result_valid_out(res_valid), .result_ready_in(res_ready),
        .hit_out(hit), .steps_out(steps), .pixel_id_out(pix_out), .rgb_out(rgb)
    );

    always #5 clk = ~clk;

    // Behavioural SDF: answers 5 cycles after each start pulse; not reset with the DUT.
    always @(posedge clk) begin
        sdf_done <= 1'b0;
        if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                sdf_done <= 1'b1;
                done_cnt <= done_cnt + 1;
                case (mode)
                    0:       sdf_dist <= -stub_z;
                    1:       sdf_dist <= 32'sh0001_0000;
                    default: sdf_dist <= 32'shFFFF_8000;
                endcase
            end
        end else if (sdf_start) begin
            stub_cnt <= 5;
            stub_z   <= sdf_z;
        end
        if (sdf_start) begin
            z_log[start_cnt[7:0]] <= sdf_z;
            start_cnt <= start_cnt + 1;
        end
    end

    function automatic fx_t fx(input int i);
        return fx_t'(i * 65536);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer_ray(input int oz, input int dz, input int m, input logic [19:0] id);
        @(negedge clk);
        mode      = m;
        origin    = '{x: fx(0), y: fx(0), z: fx(oz)};
        dir       = '{x: fx(0), y: fx(0), z: fx(dz)};
        pix_in    = id;
        ray_valid = 1'b1;
        @(negedge clk);
        ray_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!res_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 64'(res_valid), 64'd1);
    endtask

    task automatic accept_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    int base;
    int done_base;
    logic [7:0]  held_steps;
    logic [19:0] held_pix;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready",  64'(ray_ready), 64'd1);
        check("rst_rv",     64'(res_valid), 64'd0);
        check("rst_start",  64'(sdf_start), 64'd0);
        check("rst_hit",    64'(hit),       64'd0);
        check("rst_steps",  64'(steps),     64'd0);
        check("rst_rgb",    64'(rgb),       64'd0);
        check("rst_pix",    64'(pix_out),   64'd0);
        check("rst_z",      64'(sdf_z),     64'd0);
        rst = 1'b0;

        // 1: marching toward the surface, hit on second sample at z=0
        base = start_cnt;
        offer_ray(-40, 1, 0, 20'h00011);
        wait_result("t1");
        check("t1_hit",    64'(hit),     64'd1);
        check("t1_steps",  64'(steps),   64'd2);
        check("t1_rgb",    64'(rgb),     64'hA1B2C3);
        check("t1_pix",    64'(pix_out), 64'h00011);
        check("t1_pulses", 64'(start_cnt - base), 64'd2);
        check("t1_z1",     64'(z_log[base]),     64'(fx(-40)));
        check("t1_z2",     64'(z_log[base + 1]), 64'd0);
        accept_result();
        check("t1_rv_drop", 64'(res_valid), 64'd0);
        check("t1_ready",   64'(ray_ready), 64'd1);

        // 2: marching away, far clip at t+dist = 280
        base = start_cnt;
        offer_ray(-40, -1, 0, 20'h00022);
        wait_result("t2");
        check("t2_hit",    64'(hit),     64'd0);
        check("t2_steps",  64'(steps),   64'd3);
        check("t2_rgb",    64'(rgb),     64'd0);
        check("t2_pix",    64'(pix_out), 64'h00022);
        check("t2_pulses", 64'(start_cnt - base), 64'd3);
        check("t2_z3",     64'(z_log[base + 2]), 64'(fx(-160)));
        accept_result();

        // 3: constant 1.0 distance exhausts the step budget
        base = start_cnt;
        offer_ray(0, 1, 1, 20'h00033);
        wait_result("t3");
        check("t3_hit",    64'(hit),   64'd0);
        check("t3_steps",  64'(steps), 64'd64);
        check("t3_rgb",    64'(rgb),   64'd0);
        check("t3_pulses", 64'(start_cnt - base), 64'd64);
        accept_result();

        // 4: negative distance is a hit on the first sample
        offer_ray(5, 1, 2, 20'h00044);
        wait_result("t4");
        check("t4_hit",   64'(hit),   64'd1);
        check("t4_steps", 64'(steps), 64'd1);
        check("t4_rgb",   64'(rgb),   64'hA1B2C3);
        check("t4_pix",   64'(pix_out), 64'h00044);

        // 5: consumer stalls; result stays put and a new ray is refused
        held_steps = steps;
        held_pix   = pix_out;
        base       = start_cnt;
        pix_in     = 20'h00055;
        ray_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_rv",    64'(res_valid), 64'd1);
            check("t5_ready", 64'(ray_ready), 64'd0);
            check("t5_hit",   64'(hit),       64'd1);
            check("t5_steps", 64'(steps),     64'(held_steps));
            check("t5_pix",   64'(pix_out),   64'(held_pix));
        end
        ray_valid = 1'b0;
        accept_result();
        repeat (10) @(negedge clk);
        check("t5_no_take", 64'(start_cnt - base), 64'd0);
        check("t5_idle",    64'(ray_ready), 64'd1);

        // 6: reset while waiting on the SDF; late done must be ignored
        base      = start_cnt;
        done_base = done_cnt;
        offer_ray(-40, 1, 0, 20'h00066);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        base = start_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t6_rv", 64'(res_valid), 64'd0);
        end
        check("t6_done_seen", 64'(done_cnt - done_base), 64'd1);
        check("t6_no_pulse",  64'(start_cnt - base), 64'd0);
        check("t6_ready",     64'(ray_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
